// File: rtl/grf_wb_scheduler.sv
// Register-file write-port arbiter between the W stage (A) and a long-latency unit (B),
// with a per-register busy scoreboard for decode hazard stalls and bounded starvation of B.
module grf_wb_scheduler #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        b_ready,
  output logic        pipe_hold,
  input  logic        issue_valid,
  input  logic [4:0]  issue_rs,
  input  logic [4:0]  issue_rt,
  input  logic        issue_to_b,
  input  logic [4:0]  issue_rd,
  output logic        issue_stall,
  output logic        grf_we,
  output logic [4:0]  grf_waddr,
  output logic [31:0] grf_wdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [31:0] busy_r;
  logic [7:0]  wait_cnt_r;

  logic        force_s;
  logic        grant_a_s;
  logic        grant_b_s;
  logic [4:0]  waddr_s;
  logic [31:0] wdata_s;
  logic        stall_s;
  logic        set_s;
  logic [31:0] busy_nxt_s;
  logic [7:0]  wait_nxt_s;

  // Write-port arbitration: forced B grant after the wait limit, else A first, else B
  always_comb begin
    force_s   = b_valid && (wait_cnt_r == LIMIT);
    grant_b_s = force_s || (b_valid && !a_valid);
    grant_a_s = a_valid && !force_s;
    if (grant_b_s) begin
      waddr_s = b_addr;
      wdata_s = b_data;
    end else if (grant_a_s) begin
      waddr_s = a_addr;
      wdata_s = a_data;
    end else begin
      waddr_s = 5'd0;
      wdata_s = 32'd0;
    end
  end

  // Decode hazard: the registered busy bits give the same-cycle bypass behaviour for free
  always_comb begin
    stall_s = issue_valid && (busy_r[issue_rs] || busy_r[issue_rt] ||
                              (issue_to_b && busy_r[issue_rd]) || force_s);
    set_s   = issue_valid && !stall_s && issue_to_b && (issue_rd != 5'd0);
  end

  // Next-state for the starvation counter and scoreboard; set is applied after clear so it wins
  always_comb begin
    if (!b_valid || grant_b_s) begin
      wait_nxt_s = 8'd0;
    end else if (wait_cnt_r < LIMIT) begin
      wait_nxt_s = wait_cnt_r + 8'd1;
    end else begin
      wait_nxt_s = wait_cnt_r;
    end
    busy_nxt_s = busy_r;
    if (grant_b_s) begin
      busy_nxt_s[b_addr] = 1'b0;
    end else begin
      busy_nxt_s = busy_r;
    end
    if (set_s) begin
      busy_nxt_s[issue_rd] = 1'b1;
    end else begin
      busy_nxt_s[0] = 1'b0;
    end
    busy_nxt_s[0] = 1'b0;
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_r     <= 32'd0;
      wait_cnt_r <= 8'd0;
    end else begin
      busy_r     <= busy_nxt_s;
      wait_cnt_r <= wait_nxt_s;
    end
  end

  // Outputs are forced low for the whole time reset is asserted
  assign b_ready     = !reset && grant_b_s;
  assign pipe_hold   = !reset && force_s;
  assign issue_stall = !reset && stall_s;
  assign grf_we      = !reset && (grant_a_s || grant_b_s) && (waddr_s != 5'd0);
  assign grf_waddr   = reset ? 5'd0 : waddr_s;
  assign grf_wdata   = reset ? 32'd0 : wdata_s;

endmodule

// File: tb/tb_grf_wb_scheduler.sv
// Bench for grf_wb_scheduler: behavioural model compared every cycle, directed scenarios
// with literal expectations, then constrained-random traffic honouring the A/B contracts.
module tb_grf_wb_scheduler;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        a_valid, b_valid, issue_valid, issue_to_b;
  logic [4:0]  a_addr, b_addr, issue_rs, issue_rt, issue_rd;
  logic [31:0] a_data, b_data;
  logic        b_ready, pipe_hold, issue_stall, grf_we;
  logic [4:0]  grf_waddr;
  logic [31:0] grf_wdata;

  int n_checks = 0;
  int n_fail   = 0;

  // model state: which registers B still owes, and how long B has waited
  bit [31:0] m_busy;
  int        m_wait;

  logic        e_gb, e_ga, e_we, e_hold, e_stall;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata;

  logic last_hold, pend_b;

  grf_wb_scheduler #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .a_valid(a_valid), .a_addr(a_addr), .a_data(a_data),
    .b_valid(b_valid), .b_addr(b_addr), .b_data(b_data),
    .b_ready(b_ready), .pipe_hold(pipe_hold),
    .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
    .issue_to_b(issue_to_b), .issue_rd(issue_rd), .issue_stall(issue_stall),
    .grf_we(grf_we), .grf_waddr(grf_waddr), .grf_wdata(grf_wdata)
  );

  always #5 clk = ~clk;

  function automatic void model_eval();
    logic forced;
    if (reset) begin
      e_gb = 1'b0; e_ga = 1'b0; e_we = 1'b0; e_hold = 1'b0; e_stall = 1'b0;
      e_waddr = 5'd0; e_wdata = 32'd0;
    end else begin
      forced  = b_valid && (m_wait == LIMIT);
      e_gb    = forced || (b_valid && !a_valid);
      e_ga    = a_valid && !forced;
      e_hold  = forced;
      e_waddr = e_gb ? b_addr : (e_ga ? a_addr : 5'd0);
      e_wdata = e_gb ? b_data : (e_ga ? a_data : 32'd0);
      e_we    = (e_gb || e_ga) && (e_waddr != 5'd0);
      e_stall = issue_valid && (m_busy[issue_rs] || m_busy[issue_rt] ||
                                (issue_to_b && m_busy[issue_rd]) || forced);
    end
  endfunction

  function automatic void model_update();
    if (b_valid && !e_gb) m_wait = (m_wait < LIMIT) ? m_wait + 1 : m_wait;
    else                  m_wait = 0;
    if (e_gb) m_busy[b_addr] = 1'b0;
    if (issue_valid && !e_stall && issue_to_b && issue_rd != 5'd0) m_busy[issue_rd] = 1'b1;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic settle();
    #1;
    model_eval();
    chk("b_ready",     32'(b_ready),     32'(e_gb));
    chk("pipe_hold",   32'(pipe_hold),   32'(e_hold));
    chk("issue_stall", 32'(issue_stall), 32'(e_stall));
    chk("grf_we",      32'(grf_we),      32'(e_we));
    chk("grf_waddr",   32'(grf_waddr),   32'(e_waddr));
    chk("grf_wdata",   grf_wdata,        e_wdata);
  endtask

  task automatic advance();
    @(posedge clk);
    if (!reset) model_update();
    #1;
  endtask

  task automatic idle();
    a_valid = 1'b0; a_addr = 5'd0; a_data = 32'd0;
    b_valid = 1'b0; b_addr = 5'd0; b_data = 32'd0;
    issue_valid = 1'b0; issue_rs = 5'd0; issue_rt = 5'd0; issue_to_b = 1'b0; issue_rd = 5'd0;
  endtask

  initial begin
    idle();
    m_busy = 32'd0; m_wait = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // idle after reset
    settle();
    chk("idle_we", 32'(grf_we), 32'd0);
    chk("idle_bready", 32'(b_ready), 32'd0);
    chk("idle_hold", 32'(pipe_hold), 32'd0);
    chk("idle_stall", 32'(issue_stall), 32'd0);
    advance();

    // plain A write
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h1234;
    settle();
    chk("a_we", 32'(grf_we), 32'd1);
    chk("a_waddr", 32'(grf_waddr), 32'd5);
    chk("a_wdata", grf_wdata, 32'h1234);
    advance();

    // starvation: B waits four cycles then is forced in
    a_addr = 5'd10; a_data = 32'hA0A0;
    b_valid = 1'b1; b_addr = 5'd8; b_data = 32'hBEEF;
    for (int c = 1; c <= 6; c++) begin
      if (c == 6) b_valid = 1'b0;
      settle();
      if (c <= 4) begin
        chk("starve_bready", 32'(b_ready), 32'd0);
        chk("starve_waddr_a", 32'(grf_waddr), 32'd10);
      end else if (c == 5) begin
        chk("force_bready", 32'(b_ready), 32'd1);
        chk("force_hold", 32'(pipe_hold), 32'd1);
        chk("force_waddr", 32'(grf_waddr), 32'd8);
        chk("force_wdata", grf_wdata, 32'hBEEF);
      end else begin
        chk("after_waddr", 32'(grf_waddr), 32'd10);
        chk("after_hold", 32'(pipe_hold), 32'd0);
      end
      advance();
    end

    // RAW hazard on a register owed by B
    idle();
    issue_valid = 1'b1; issue_to_b = 1'b1; issue_rd = 5'd9; issue_rs = 5'd1; issue_rt = 5'd2;
    settle();
    chk("disp9_stall", 32'(issue_stall), 32'd0);
    advance();
    issue_to_b = 1'b0; issue_rd = 5'd0; issue_rs = 5'd9; issue_rt = 5'd0;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("raw9_stall", 32'(issue_stall), 32'd1);
      advance();
    end
    b_valid = 1'b1; b_addr = 5'd9; b_data = 32'h99;
    settle();
    chk("raw9_bypass_stall", 32'(issue_stall), 32'd1);
    chk("raw9_bready", 32'(b_ready), 32'd1);
    advance();
    b_valid = 1'b0;
    settle();
    chk("raw9_release", 32'(issue_stall), 32'd0);
    advance();

    // $0 destination: never busy, never written
    idle();
    issue_valid = 1'b1; issue_to_b = 1'b1; issue_rd = 5'd0;
    settle();
    advance();
    settle();
    chk("rd0_stall", 32'(issue_stall), 32'd0);
    advance();
    idle();
    b_valid = 1'b1; b_addr = 5'd0; b_data = 32'h5555;
    settle();
    chk("b0_bready", 32'(b_ready), 32'd1);
    chk("b0_we", 32'(grf_we), 32'd0);
    advance();

    // same-cycle clear and set of reg 3: set wins
    idle();
    b_valid = 1'b1; b_addr = 5'd3; b_data = 32'h33;
    issue_valid = 1'b1; issue_to_b = 1'b1; issue_rd = 5'd3;
    settle();
    chk("setclr_bready", 32'(b_ready), 32'd1);
    chk("setclr_stall", 32'(issue_stall), 32'd0);
    advance();
    idle();
    issue_valid = 1'b1; issue_rs = 5'd3;
    settle();
    chk("set_wins_stall", 32'(issue_stall), 32'd1);
    advance();

    // asynchronous reset mid-cycle
    a_valid = 1'b1; a_addr = 5'd5; a_data = 32'h77;
    settle();
    #2 reset = 1'b1;
    m_busy = 32'd0; m_wait = 0;
    settle();
    chk("rst_we", 32'(grf_we), 32'd0);
    chk("rst_stall", 32'(issue_stall), 32'd0);
    chk("rst_waddr", 32'(grf_waddr), 32'd0);
    advance();
    reset = 1'b0;
    a_valid = 1'b0;
    settle();
    chk("rst_busy3_clear", 32'(issue_stall), 32'd0);
    advance();

    // constrained-random traffic
    idle();
    last_hold = 1'b0; pend_b = 1'b0;
    for (int n = 0; n < 2000; n++) begin
      if (!last_hold) begin
        a_valid = ($urandom_range(0, 9) < 7);
        a_addr  = 5'($urandom_range(0, 31));
        a_data  = $urandom;
      end
      if (!pend_b) begin
        b_valid = ($urandom_range(0, 2) == 0);
        b_addr  = 5'($urandom_range(0, 7));
        b_data  = $urandom;
      end
      issue_valid = ($urandom_range(0, 1) == 1);
      issue_rs    = 5'($urandom_range(0, 7));
      issue_rt    = 5'($urandom_range(0, 7));
      issue_rd    = 5'($urandom_range(0, 7));
      issue_to_b  = ($urandom_range(0, 2) == 0);
      settle();
      last_hold = e_hold;
      pend_b    = b_valid && !e_gb;
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grf_wb_scheduler.md
Name: grf_wb_scheduler

Overview:
- Sits between the pipeline and the 32x32 register file's single write port.
- Shares that port between two writers: the in-order pipeline W stage (source A) and a long-latency unit such as a mult/div unit (source B).
- Keeps a per-register busy scoreboard for results still owed by source B, and tells decode to stall when an instruction reads one of those registers.
- Forces a grant to B after a bounded wait, so the pipeline cannot starve it.

Parameters:
STARVE_LIMIT, 4, consecutive cycles B may wait ungranted before a forced grant; legal range 1..255.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high; clears all state
a_valid  input  1  W stage has a register write this cycle
a_addr  input  5  W-stage destination register
a_data  input  32  W-stage write data
b_valid  input  1  long-latency unit has a result pending
b_addr  input  5  long-latency unit destination register
b_data  input  32  long-latency unit result
b_ready  output  1  B's result is written this cycle (handshake completes)
pipe_hold  output  1  freeze the W stage and everything upstream this cycle
issue_valid  input  1  decode is issuing an instruction this cycle
issue_rs  input  5  source register 1 of the issuing instruction
issue_rt  input  5  source register 2 of the issuing instruction
issue_to_b  input  1  issuing instruction is dispatched to B and writes issue_rd
issue_rd  input  5  destination register of a B-dispatched instruction
issue_stall  output  1  hazard: decode must not issue this cycle
grf_we  output  1  register-file write enable
grf_waddr  output  5  register-file write address
grf_wdata  output  32  register-file write data

Behaviour:
- State:
  - busy[31:1]: scoreboard bits; busy[0] is hardwired to 0.
  - wait_cnt: 8-bit counter.
  - All state resets to 0 asynchronously.
  - While reset is high, every output is 0.
- Arbitration (combinational from inputs and wait_cnt; zero latency):
  - Forced case, when b_valid && wait_cnt == STARVE_LIMIT: force = 1. B is granted, pipe_hold = 1, A is not written. The pipeline holds a_valid/a_addr/a_data stable into the next cycle.
  - Otherwise, when a_valid: A is granted, b_ready = 0, pipe_hold = 0.
  - Otherwise, when b_valid: B is granted, b_ready = 1.
  - Otherwise: nothing is granted and grf_we = 0.
  - b_ready = 1 exactly when B is granted.
- Write-port outputs:
  - grf_waddr and grf_wdata carry the granted source's address and data.
  - grf_we = granted && waddr != 0.
  - A B grant to $0 still asserts b_ready, so the handshake completes, but nothing is written.
- wait_cnt:
  - Cleared on a B grant or when !b_valid.
  - Incremented when b_valid && !b_ready.
  - Saturates at STARVE_LIMIT.
- Scoreboard, updated at posedge:
  - B grant: clears busy[b_addr].
  - issue_valid && !issue_stall && issue_to_b && issue_rd != 0: sets busy[issue_rd].
  - Set and clear of the same register in the same cycle: set wins.
- issue_stall (combinational) is asserted when issue_valid and any of these holds:
  - busy[issue_rs]
  - busy[issue_rt]
  - issue_to_b && busy[issue_rd] (WAW)
  - pipe_hold
- Bypass: a register cleared by a B grant in the current cycle still reads as busy that cycle. The stall releases the following cycle, when the register file already holds the value.
- Source B contract: results return in dispatch order, and b_valid, b_addr and b_data stay stable until b_ready.
- Reset mid-handshake: state clears immediately and any pending B result is dropped. Flushing B is the caller's responsibility.

Test Plan:
- Reset, then idle with all inputs 0 -> grf_we = 0, b_ready = 0, pipe_hold = 0, issue_stall = 0, busy = 0.
- a_valid = 1, a_addr = 5, a_data = 0x1234 with b_valid = 0 -> grf_we = 1, grf_waddr = 5, grf_wdata = 0x1234 in the same cycle.
- b_valid = 1, b_addr = 8 with a_valid high for 6 cycles -> cycles 1-4: A written, b_ready = 0, wait_cnt goes 1, 2, 3, 4. Cycle 5: b_ready = 1, pipe_hold = 1, grf_waddr = 8. Cycle 6: A written again, wait_cnt = 0.
- Issue to_b with rd = 9, then next cycle issue rs = 9 -> issue_stall = 1. It stays high through the cycle in which B is granted with b_addr = 9 and drops the cycle after.
- Issue to_b rd = 0 -> busy unchanged. B grant with b_addr = 0 -> b_ready = 1, grf_we = 0.
- Same cycle: B granted with b_addr = 3 and issue to_b with rd = 3, where busy[3] was clear -> busy[3] = 1 afterwards. Then assert reset asynchronously mid-cycle -> busy[3] = 0 and all outputs 0 immediately.
